// File: rtl/fp32_align_stage_pkg.sv
// Shared fp32 field layout and width helpers for the fp adder tree front end.
package fp_adder_tree_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int BIAS   = 127;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp32_t;

    // Lane: sign + hidden integer bit + FRAC fraction bits.
    function automatic int lane_w(input int frac);
        return frac + 2;
    endfunction

    function automatic int sum_w(input int n, input int frac);
        return frac + 2 + $clog2(n);
    endfunction

endpackage

// File: rtl/fp32_align_stage_if.sv
// Input group / aligned output group handshake bundle for fp32_align_stage.
interface fp32_align_stage_if #(
    parameter int N      = 8,
    parameter int LANE_W = 48
);
    import fp_adder_tree_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [N*32-1:0]       in_fp;
    logic                  out_valid;
    logic                  out_ready;
    logic [N*LANE_W-1:0]   out_lane;
    logic [EXP_W-1:0]      out_exp;
    logic                  out_zero;
    logic                  out_special;

    modport master (
        output in_valid, in_fp, out_ready,
        input  in_ready, out_valid, out_lane, out_exp, out_zero, out_special
    );

    modport slave (
        input  in_valid, in_fp, out_ready,
        output in_ready, out_valid, out_lane, out_exp, out_zero, out_special
    );

endinterface

// File: rtl/fp32_align_stage_max_tree.sv
// Combinational log2(N)-level max tree over biased exponent fields.
module fp_max_exp_tree
    import fp_adder_tree_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0][EXP_W-1:0] exp_i,
    output logic [EXP_W-1:0]        emax_o
);
    localparam int LVL = $clog2(N);

    // Zero/denormal fields are 0, so they can never win a compare: masking is free.
    for (genvar l = 0; l <= LVL; l++) begin : g_lvl
        logic [(N>>l)-1:0][EXP_W-1:0] v;
        if (l == 0) begin : g_leaf
            assign v = exp_i;
        end else begin : g_cmp
            for (genvar j = 0; j < (N >> l); j++) begin : g_j
                assign v[j] = (g_lvl[l-1].v[2*j] > g_lvl[l-1].v[2*j+1]) ?
                              g_lvl[l-1].v[2*j] : g_lvl[l-1].v[2*j+1];
            end
        end
    end

    assign emax_o = g_lvl[LVL].v[0];

endmodule

// File: rtl/fp32_align_stage.sv
// Two-stage fp32 group aligner: S1 finds the group max exponent, S2 shifts every
// operand into a two's-complement fixed-point lane relative to that exponent.
module fp32_align_stage
    import fp_adder_tree_pkg::*;
#(
    parameter int N      = 8,
    parameter int FRAC   = 46,
    parameter int LANE_W = lane_w(FRAC)
) (
    input  logic           clk,
    input  logic           rst,
    fp32_align_stage_if.slave bus
);
    localparam int               SH     = FRAC - MANT_W;
    localparam logic [EXP_W:0]   D_LIM  = (EXP_W+1)'(FRAC + 1);
    localparam logic [EXP_W-1:0] BIAS_E = EXP_W'(BIAS);

    logic [2:1]                 vld_q;
    logic                       rdy1, rdy2;
    fp32_t [N-1:0]              op_in, op_q;
    logic [N-1:0][EXP_W-1:0]    exp_in;
    logic [EXP_W-1:0]           emax_d, emax_q;
    logic [N-1:0][LANE_W-1:0]   lane_d, lane_q;
    logic [EXP_W-1:0]           exp_q;
    logic                       zero_q, special_q;

    assign rdy2         = !vld_q[2] || bus.out_ready;
    assign rdy1         = !vld_q[1] || rdy2;
    assign bus.in_ready = rdy1;

    assign op_in = bus.in_fp;

    for (genvar i = 0; i < N; i++) begin : g_exp
        assign exp_in[i] = op_in[i].exp;
    end

    fp_max_exp_tree #(.N(N)) u_max (
        .exp_i  (exp_in),
        .emax_o (emax_d)
    );

    // Per-lane alignment: bits shifted past the LSB are truncated, not rounded.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [EXP_W:0]    d;
        logic [LANE_W-1:0] sig, mag;
        assign d         = {1'b0, emax_q} - {1'b0, op_q[i].exp};
        assign sig       = LANE_W'({1'b1, op_q[i].mant}) << SH;
        assign mag       = (op_q[i].exp == '0 || d >= D_LIM) ? '0 : sig >> d;
        assign lane_d[i] = op_q[i].sign ? -mag : mag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= '0;
            op_q      <= '0;
            emax_q    <= '0;
            lane_q    <= '0;
            exp_q     <= '0;
            zero_q    <= 1'b0;
            special_q <= 1'b0;
        end else begin
            if (rdy1) vld_q[1] <= bus.in_valid;
            if (rdy2) vld_q[2] <= vld_q[1];
            if (rdy1 && bus.in_valid) begin
                op_q   <= op_in;
                emax_q <= emax_d;
            end
            // Any field of 255 forces emax to 255, so the flags fall out of emax.
            if (rdy2 && vld_q[1]) begin
                lane_q    <= lane_d;
                exp_q     <= emax_q - BIAS_E;
                zero_q    <= (emax_q == '0);
                special_q <= (emax_q == '1);
            end
        end
    end

    assign bus.out_valid   = vld_q[2];
    assign bus.out_lane    = lane_q;
    assign bus.out_exp     = exp_q;
    assign bus.out_zero    = zero_q;
    assign bus.out_special = special_q;

endmodule
